// File: rtl/gray_capture_ctrl.sv
// Frame-capture sequencer for the RGB-to-grayscale stage.
// Arms on start, tracks X/Y, emits ROI strobe aligned to gray output.
module gray_capture_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ROI_X0   = 160,
  parameter int ROI_Y0   = 120,
  parameter int ROI_W    = 320,
  parameter int ROI_H    = 240,
  parameter int GRAY_LAT = 1
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iSTART,
  input  logic       iFVAL,
  input  logic       iDVAL,
  output logic       oROI_VAL,
  output logic [9:0] oX,
  output logic [9:0] oY,
  output logic       oBUSY,
  output logic       oDONE,
  output logic       oERR,
  output logic [7:0] oFRAME_CNT
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [9:0] L_XMAX = 10'(H_ACTIVE - 1);
  localparam logic [9:0] L_YMAX = 10'(V_ACTIVE - 1);
  localparam logic [9:0] L_X0   = 10'(ROI_X0);
  localparam logic [9:0] L_X1   = 10'(ROI_X0 + ROI_W - 1);
  localparam logic [9:0] L_Y0   = 10'(ROI_Y0);
  localparam logic [9:0] L_Y1   = 10'(ROI_Y0 + ROI_H - 1);

  logic [1:0] r_state;
  logic       r_fval;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_busy;
  logic       r_done;
  logic       r_err;
  logic [7:0] r_cnt;

  logic [GRAY_LAT-1:0]       r_dv;
  logic [GRAY_LAT-1:0]       r_dl;
  logic [GRAY_LAT-1:0][9:0]  r_dx;
  logic [GRAY_LAT-1:0][9:0]  r_dy;

  logic                      w_rise;
  logic                      w_fall;
  logic                      w_inroi;
  logic                      w_push;
  logic                      w_last;
  logic                      w_out_last;
  logic [GRAY_LAT:0]         w_sv;
  logic [GRAY_LAT:0]         w_sl;
  logic [GRAY_LAT:0][9:0]    w_sx;
  logic [GRAY_LAT:0][9:0]    w_sy;

  assign w_rise  = iFVAL & ~r_fval;
  assign w_fall  = ~iFVAL & r_fval;
  assign w_inroi = (r_x >= L_X0) && (r_x <= L_X1) &&
                   (r_y >= L_Y0) && (r_y <= L_Y1);
  assign w_push  = (r_state == S_CAP) && iDVAL;
  assign w_last  = w_push && (r_x == L_X1) && (r_y == L_Y1);

  // Stage 0 input sits at index 0; stage i takes index i.
  assign w_sv = {r_dv, w_push & w_inroi};
  assign w_sl = {r_dl, w_last};
  assign w_sx = {r_dx, r_x};
  assign w_sy = {r_dy, r_y};

  assign w_out_last = r_dv[GRAY_LAT-1] & r_dl[GRAY_LAT-1];

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state <= S_IDLE;
      r_fval  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_fval <= iFVAL;
      r_busy <= (r_state == S_ARM) || (r_state == S_CAP);
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (iSTART) r_state <= S_ARM;
        end
        S_ARM: begin
          if (w_rise) begin
            r_x     <= '0;
            r_y     <= '0;
            r_state <= S_CAP;
          end
        end
        S_CAP: begin
          if (w_push) begin
            if (r_x == L_XMAX) begin
              r_x <= '0;
              if (r_y != L_YMAX) r_y <= r_y + 10'd1;
            end else begin
              r_x <= r_x + 10'd1;
            end
          end
          if (w_last) begin
            r_state <= S_DONE;
          end else if (w_fall) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_DONE: begin
          if (w_out_last) begin
            r_done  <= 1'b1;
            r_cnt   <= r_cnt + 8'd1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output stage keeps its coordinates when no ROI pixel arrives.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_dv <= '0;
      r_dl <= '0;
      r_dx <= '0;
      r_dy <= '0;
    end else begin
      for (int i = 0; i < GRAY_LAT; i++) begin
        r_dv[i] <= w_sv[i];
        r_dl[i] <= w_sl[i];
        if ((i != GRAY_LAT - 1) || w_sv[i]) begin
          r_dx[i] <= w_sx[i];
          r_dy[i] <= w_sy[i];
        end
      end
    end
  end

  assign oROI_VAL   = r_dv[GRAY_LAT-1];
  assign oX         = r_dx[GRAY_LAT-1];
  assign oY         = r_dy[GRAY_LAT-1];
  assign oBUSY      = r_busy;
  assign oDONE      = r_done;
  assign oERR       = r_err;
  assign oFRAME_CNT = r_cnt;

endmodule
